bt656_pattern_gen: RTL

Synthetic ITU-R BT.656 source for 625-line/50 Hz interlaced video (PAL timing). Drives the same 8-bit `bt_data` bus that the BT.656-to-Avalon-ST converter consumes.
- Replaces the camera/decoder for bring-up and for closed-loop testing of the capture path.
- Emits EAV/SAV timing codes with correct protection bits, horizontal blanking and selectable active-video test patterns, all in the `bt_clock` domain.

---
 rtl/bt656_pattern_gen.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/bt656_pattern_gen.sv
// ---------------------------------------------------------------------------
// bt656_pattern_gen
//
// Synthetic ITU-R BT.656 byte source for 625-line / 50 Hz interlaced video.
// Emits EAV/SAV timing codes, horizontal blanking fill and a selectable
// active-video test pattern. Free running: there is no backpressure and no
// input handshake. Every output is registered.
//
// Ports:
//   bt_clock     in   byte clock (27 MHz nominal)
//   reset        in   asynchronous, active-high
//   enable       in   active content enable, sampled at frame start
//   pattern_sel  in   0=ramp, 1=colour bars, 2=line id, 3=flat black;
//                     sampled at frame start
//   bt_data      out  BT.656 byte stream
//   field        out  F bit of the line being emitted
//   vblank       out  V bit of the line being emitted
//   active       out  high while bt_data carries active-video bytes
//   line_num     out  current frame line, 1..625
//   frame_start  out  one-cycle pulse on the first EAV byte of line 1
// ---------------------------------------------------------------------------
module bt656_pattern_gen #(
   parameter int LINE_WIDTH  = 720,
   parameter int BLANK_WIDTH = 280,
   parameter int BAR_WIDTH   = 90
) (
   input  logic       bt_clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   output logic [7:0] bt_data,
   output logic       field,
   output logic       vblank,
   output logic       active,
   output logic [9:0] line_num,
   output logic       frame_start
);

   localparam int LINE_LEN = 8 + BLANK_WIDTH + 2 * LINE_WIDTH;
   localparam int H_W      = $clog2(LINE_LEN);
   localparam int BAR_W    = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

   localparam logic [H_W-1:0]   BLANK_H  = H_W'(4);
   localparam logic [H_W-1:0]   SAV_H    = H_W'(4 + BLANK_WIDTH);
   localparam logic [H_W-1:0]   ACT_H    = H_W'(8 + BLANK_WIDTH);
   localparam logic [H_W-1:0]   LAST_H   = H_W'(LINE_LEN - 1);
   localparam logic [H_W-1:0]   H_ONE    = H_W'(1);
   localparam logic [BAR_W-1:0] BAR_LAST = BAR_W'(BAR_WIDTH - 1);
   localparam logic [BAR_W-1:0] BAR_ONE  = BAR_W'(1);
   // Alignment of the SAV code and of the active region relative to h, so
   // the code position and Cb/Y/Cr phase come from the low bits of h.
   localparam logic [1:0]       SAV_PH   = 2'((4 + BLANK_WIDTH) % 4);
   localparam logic             ACT_PH   = 1'((8 + BLANK_WIDTH) % 2);

   // Position of the byte emitted on the next edge.
   logic [H_W-1:0]   h_cnt;
   logic [9:0]       line_cnt;
   // Frame-latched controls.
   logic [1:0]       pat_q;
   logic             en_q;
   // Colour-bar tracking: pixel within bar and bar index.
   logic [BAR_W-1:0] bar_pix;
   logic [2:0]       bar_idx;

   logic             frame_first;
   logic [1:0]       pat_eff;
   logic             en_eff;
   logic             f_cur;
   logic             v_cur;
   logic             in_eav;
   logic             in_sav;
   logic             in_act;
   logic             active_now;
   logic [H_W-1:0]   act_off;
   logic [1:0]       code_pos;
   logic [7:0]       xy;
   logic [7:0]       timing_byte;
   logic [7:0]       fill_byte;
   logic [7:0]       ramp_y;
   logic [7:0]       bar_y;
   logic [7:0]       bar_cb;
   logic [7:0]       bar_cr;
   logic [7:0]       pix_y;
   logic [7:0]       pix_cb;
   logic [7:0]       pix_cr;
   logic [7:0]       pix_byte;
   logic [7:0]       next_byte;

   // ------------------------------------------------------------------
   // Byte selection for the current (line, h)
   // ------------------------------------------------------------------
   always_comb begin
      frame_first = (line_cnt == 10'd1) && (h_cnt == '0);
      // On the frame's first byte the live inputs are used, so the value
      // latched on that edge already governs the whole frame.
      pat_eff     = frame_first ? pattern_sel : pat_q;
      en_eff      = frame_first ? enable : en_q;

      f_cur = (line_cnt >= 10'd313);
      v_cur = (line_cnt <= 10'd22) ||
              ((line_cnt >= 10'd311) && (line_cnt <= 10'd335)) ||
              (line_cnt >= 10'd624);

      in_eav     = (h_cnt < BLANK_H);
      in_sav     = (h_cnt >= SAV_H) && (h_cnt < ACT_H);
      in_act     = (h_cnt >= ACT_H);
      active_now = in_act && !v_cur;
      act_off    = h_cnt - ACT_H;

      code_pos = in_eav ? h_cnt[1:0] : (h_cnt[1:0] - SAV_PH);
      xy = {1'b1, f_cur, v_cur, in_eav,
            v_cur ^ in_eav, f_cur ^ in_eav, f_cur ^ v_cur,
            f_cur ^ v_cur ^ in_eav};
      case (code_pos)
         2'd0:    timing_byte = 8'hFF;
         2'd3:    timing_byte = xy;
         default: timing_byte = 8'h00;
      endcase

      // Blanking fill: 0x80 on even offsets, 0x10 on odd ones, in both the
      // horizontal blanking and a suppressed active region.
      if (in_act) fill_byte = (h_cnt[0] ^ ACT_PH) ? 8'h10 : 8'h80;
      else        fill_byte = h_cnt[0] ? 8'h10 : 8'h80;

      // Ramp: one code step every four pixels (eight bytes).
      ramp_y = 8'h10 + 8'(act_off >> 3);

      case (bar_idx)
         3'd0:    begin bar_y = 8'hB4; bar_cb = 8'h80; bar_cr = 8'h80; end
         3'd1:    begin bar_y = 8'hA2; bar_cb = 8'h2C; bar_cr = 8'h8E; end
         3'd2:    begin bar_y = 8'h83; bar_cb = 8'h9C; bar_cr = 8'h2C; end
         3'd3:    begin bar_y = 8'h70; bar_cb = 8'h48; bar_cr = 8'h3A; end
         3'd4:    begin bar_y = 8'h54; bar_cb = 8'hB8; bar_cr = 8'hC6; end
         3'd5:    begin bar_y = 8'h41; bar_cb = 8'h64; bar_cr = 8'hD4; end
         3'd6:    begin bar_y = 8'h23; bar_cb = 8'hD4; bar_cr = 8'h72; end
         default: begin bar_y = 8'h10; bar_cb = 8'h80; bar_cr = 8'h80; end
      endcase

      case (pat_eff)
         2'd0: begin
            pix_y = ramp_y;  pix_cb = 8'h80;  pix_cr = 8'h80;
         end
         2'd1: begin
            pix_y = bar_y;   pix_cb = bar_cb; pix_cr = bar_cr;
         end
         2'd2: begin
            pix_y  = 8'h10 + {1'b0, line_cnt[6:0]};
            pix_cb = f_cur ? 8'hC0 : 8'h80;
            pix_cr = 8'h80;
         end
         default: begin
            pix_y = 8'h10;   pix_cb = 8'h80;  pix_cr = 8'h80;
         end
      endcase

      // Component order within each pixel pair: Cb, Y, Cr, Y.
      if (act_off[0])      pix_byte = pix_y;
      else if (act_off[1]) pix_byte = pix_cr;
      else                 pix_byte = pix_cb;

      if (in_eav || in_sav)        next_byte = timing_byte;
      else if (active_now && en_eff) next_byte = pix_byte;
      else                         next_byte = fill_byte;
   end

   // ------------------------------------------------------------------
   // Registered outputs and frame-latched controls
   // ------------------------------------------------------------------
   always_ff @(posedge bt_clock or posedge reset) begin
      if (reset) begin
         bt_data     <= 8'h10;
         field       <= 1'b0;
         vblank      <= 1'b1;
         active      <= 1'b0;
         line_num    <= 10'd1;
         frame_start <= 1'b0;
         pat_q       <= 2'd0;
         en_q        <= 1'b0;
      end else begin
         bt_data     <= next_byte;
         field       <= f_cur;
         vblank      <= v_cur;
         active      <= active_now;
         line_num    <= line_cnt;
         frame_start <= frame_first;
         if (frame_first) begin
            pat_q <= pattern_sel;
            en_q  <= enable;
         end
      end
   end

   // ------------------------------------------------------------------
   // Raster position
   // ------------------------------------------------------------------
   always_ff @(posedge bt_clock or posedge reset) begin
      if (reset) begin
         h_cnt    <= '0;
         line_cnt <= 10'd1;
      end else if (h_cnt == LAST_H) begin
         h_cnt    <= '0;
         line_cnt <= (line_cnt == 10'd625) ? 10'd1 : line_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + H_ONE;
      end
   end

   // ------------------------------------------------------------------
   // Colour-bar index: cleared on the last SAV byte, then stepped once per
   // BAR_WIDTH pixels (a pixel ends on every odd active byte). Saturates
   // at the last bar.
   // ------------------------------------------------------------------
   always_ff @(posedge bt_clock or posedge reset) begin
      if (reset) begin
         bar_pix <= '0;
         bar_idx <= 3'd0;
      end else if (h_cnt == ACT_H - H_ONE) begin
         bar_pix <= '0;
         bar_idx <= 3'd0;
      end else if (in_act && act_off[0]) begin
         if (bar_pix == BAR_LAST) begin
            bar_pix <= '0;
            if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_pix <= bar_pix + BAR_ONE;
         end
      end
   end

endmodule
